// File: rtl/k16_bus_if.sv
// K16 memory bus: one synchronous word-addressed port with a one-cycle read latency.
interface k16_bus_if;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        write;

    modport master (
        output address,
        output data_out,
        output write,
        input  data_in
    );

    modport slave (
        input  address,
        input  data_out,
        input  write,
        output data_in
    );
endinterface

// File: rtl/k16_cpu.sv
// K16 multi-cycle core: eight registers, Z/N/C flags, 8-opcode ISA, one memory bus.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | address = PC, issue instruction read
// WAIT    | address = PC, read data in flight
// EXEC    | instruction on data_in; commit non-memory ops, or start LD/ST
// MEM     | address = EA; a store drives write/data_out for this one cycle
// MWAIT   | address = EA, load data in flight
// LOAD    | load data on data_in, written to the target register
// HALT    | terminal; only reset leaves it
module k16_cpu #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic      clk,
    input  logic      reset,
    output logic      hold,
    output logic      busy,
    k16_bus_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_MEM,
        S_MWAIT,
        S_LOAD,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LDST = 3'b010;
    localparam logic [2:0] OP_LDI  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_BR   = 3'b101;
    localparam logic [2:0] OP_JAL  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] regs [8];
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic        ir_store;
    logic [2:0]  ir_reg;

    // Instruction fields, decoded straight off the bus while in EXEC.
    logic [15:0] instr;
    logic [2:0]  op;
    logic [2:0]  f_rd;
    logic [2:0]  f_ra;
    logic [2:0]  f_rb;
    logic [3:0]  func;
    logic [15:0] ra_val;
    logic [15:0] rb_val;
    logic [15:0] base_val;
    logic [15:0] st_val;
    logic [15:0] pc_inc;

    assign instr    = bus.data_in;
    assign op       = instr[15:13];
    assign f_rd     = instr[12:10];
    assign f_ra     = instr[9:7];
    assign f_rb     = instr[6:4];
    assign func     = instr[3:0];
    assign ra_val   = regs[f_ra];
    assign rb_val   = regs[f_rb];
    assign base_val = regs[instr[8:6]];
    assign st_val   = regs[instr[11:9]];
    assign pc_inc   = pc + 16'd1;

    // Execute-stage results: bit 16 of res carries the C flag value.
    logic [16:0] res;
    logic        wr_en;
    logic        flg_en;
    logic        br_taken;
    logic [15:0] next_pc;
    logic [15:0] mem_ea;

    // Branch condition evaluation against the committed flags.
    always_comb begin
        br_taken = 1'b0;
        case (instr[12:10])
            3'd0: br_taken = flag_z;
            3'd1: br_taken = ~flag_z;
            3'd2: br_taken = flag_c;
            3'd3: br_taken = ~flag_c;
            3'd4: br_taken = flag_n;
            3'd5: br_taken = ~flag_n;
            3'd6: br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    // Datapath: result, register/flag write enables, next PC and effective address.
    always_comb begin
        res     = '0;
        wr_en   = 1'b0;
        flg_en  = 1'b0;
        next_pc = pc_inc;
        mem_ea  = base_val + {{10{instr[5]}}, instr[5:0]};
        case (op)
            OP_ALU: begin
                // funcs 8..15 leave everything untouched
                if (!func[3]) begin
                    wr_en  = 1'b1;
                    flg_en = 1'b1;
                    case (func[2:0])
                        3'd0: res = {1'b0, ra_val} + {1'b0, rb_val};
                        3'd1: res = {(ra_val < rb_val), ra_val - rb_val};
                        3'd2: res = {1'b0, ra_val & rb_val};
                        3'd3: res = {1'b0, ra_val | rb_val};
                        3'd4: res = {1'b0, ra_val ^ rb_val};
                        3'd5: res = {ra_val[15], ra_val[14:0], 1'b0};
                        3'd6: res = {ra_val[0], 1'b0, ra_val[15:1]};
                        default: res = {1'b0, rb_val};
                    endcase
                end
            end
            OP_ADDI: begin
                wr_en  = 1'b1;
                flg_en = 1'b1;
                res    = {1'b0, ra_val} + {1'b0, {9{instr[6]}}, instr[6:0]};
            end
            OP_LDI: begin
                wr_en = 1'b1;
                res   = {7'b0, instr[9:0]};
            end
            OP_JMP: begin
                next_pc = pc_inc + {{3{instr[12]}}, instr[12:0]};
            end
            OP_BR: begin
                if (br_taken) begin
                    next_pc = pc_inc + {{6{instr[9]}}, instr[9:0]};
                end
            end
            OP_JAL: begin
                // target comes from the pre-commit ra, so rd == ra still jumps to old ra
                wr_en   = 1'b1;
                res     = {1'b0, pc_inc};
                next_pc = ra_val;
            end
            default: begin
                res = '0;
            end
        endcase
    end

    // Sequencer: state, architectural registers and registered bus outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            flag_z       <= 1'b0;
            flag_n       <= 1'b0;
            flag_c       <= 1'b0;
            ir_store     <= 1'b0;
            ir_reg       <= '0;
            hold         <= 1'b0;
            busy         <= 1'b0;
            bus.address  <= RESET_PC;
            bus.data_out <= '0;
            bus.write    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    state <= S_WAIT;
                    busy  <= 1'b1;
                end
                S_WAIT: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    ir_store <= instr[12];
                    ir_reg   <= instr[11:9];
                    if (op == OP_HALT) begin
                        state <= S_HALT;
                        hold  <= 1'b1;
                    end else if (op == OP_LDST) begin
                        state       <= S_MEM;
                        pc          <= pc_inc;
                        bus.address <= mem_ea;
                        if (instr[12]) begin
                            bus.write    <= 1'b1;
                            bus.data_out <= st_val;
                        end
                    end else begin
                        if (wr_en) begin
                            regs[f_rd] <= res[15:0];
                        end
                        if (flg_en) begin
                            flag_z <= (res[15:0] == 16'h0000);
                            flag_n <= res[15];
                            flag_c <= res[16];
                        end
                        pc          <= next_pc;
                        bus.address <= next_pc;
                        state       <= S_FETCH;
                        busy        <= 1'b0;
                    end
                end
                S_MEM: begin
                    bus.write    <= 1'b0;
                    bus.data_out <= '0;
                    if (ir_store) begin
                        state       <= S_FETCH;
                        bus.address <= pc;
                        busy        <= 1'b0;
                    end else begin
                        state <= S_MWAIT;
                    end
                end
                S_MWAIT: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    regs[ir_reg] <= bus.data_in;
                    state        <= S_FETCH;
                    bus.address  <= pc;
                    busy         <= 1'b0;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_k16_cpu.sv
// Bench for k16_cpu: synchronous memory, ISA-level reference interpreter, store scoreboard.
module tb_k16_cpu;

    logic clk = 1'b0;
    logic reset;
    logic hold;
    logic busy;

    k16_bus_if bus ();

    k16_cpu #(.RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .busy  (busy),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Memory: img is the preloaded image, DUT stores land in an overlay tagged by test generation.
    logic [15:0] img  [65536];
    logic [15:0] wdat [65536];
    int unsigned wgen [65536];
    int unsigned gen;

    always @(posedge clk) begin
        if (bus.write) begin
            wdat[bus.address] <= bus.data_out;
            wgen[bus.address] <= gen;
        end
        bus.data_in <= (wgen[bus.address] == gen) ? wdat[bus.address] : img[bus.address];
    end

    int n_checks;
    int n_pass;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;
    bit mon_en;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Scoreboard monitor: every store strobe must match the next expected {address, data}.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (bus.write) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL store_unexpected: got store %h <= %h expected no store", bus.address, bus.data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("store_addr", {16'h0, bus.address}, {16'h0, mon_e[31:16]});
                    check("store_data", {16'h0, bus.data_out}, {16'h0, mon_e[15:0]});
                end
            end else begin
                check("data_out_idle", {16'h0, bus.data_out}, 32'h0);
            end
        end
    end

    // Reference ISA interpreter.
    logic [15:0] mm [65536];
    logic [15:0] mr [8];
    bit mz, mn, mc;
    int exp_cyc;
    logic [15:0] exp_hpc;

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    task automatic model_run(output bit ok);
        logic [15:0] pc, ins, ea, t;
        int unsigned a, b, s, r;
        bit carry, taken, done;
        int rd, ra, rb;
        pc = 16'h0000; exp_cyc = 0; ok = 0; done = 0; exp_hpc = 16'h0;
        for (int i = 0; i < 8; i++) mr[i] = 16'h0;
        mz = 0; mn = 0; mc = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            ins = mm[pc];
            rd = int'(ins[12:10]); ra = int'(ins[9:7]); rb = int'(ins[6:4]);
            a = int'(mr[ra]); b = int'(mr[rb]);
            r = 0; carry = 0;
            case (ins[15:13])
                3'd0: begin
                    exp_cyc += 3;
                    if (ins[3] == 1'b0) begin
                        case (ins[2:0])
                            3'd0: begin s = a + b; r = s & 32'hFFFF; carry = (s > 32'hFFFF); end
                            3'd1: begin r = (a + 32'h10000 - b) & 32'hFFFF; carry = (a < b); end
                            3'd2: r = a & b;
                            3'd3: r = a | b;
                            3'd4: r = a ^ b;
                            3'd5: begin r = (a * 2) & 32'hFFFF; carry = (a >= 32'h8000); end
                            3'd6: begin r = a / 2; carry = (a % 2) == 1; end
                            default: r = b;
                        endcase
                        mr[rd] = r[15:0]; mz = (r == 0); mn = (r >= 32'h8000); mc = carry;
                    end
                    pc = pc + 16'd1;
                end
                3'd1: begin
                    exp_cyc += 3;
                    s = a + (int'(sx(int'(ins[6:0]), 7)) & 32'hFFFF);
                    r = s & 32'hFFFF;
                    mr[rd] = r[15:0]; mz = (r == 0); mn = (r >= 32'h8000); mc = (s > 32'hFFFF);
                    pc = pc + 16'd1;
                end
                3'd2: begin
                    ea = mr[ins[8:6]] + 16'(sx(int'(ins[5:0]), 6));
                    if (ins[12]) begin
                        exp_cyc += 4;
                        mm[ea] = mr[ins[11:9]];
                        exp_q.push_back({ea, mr[ins[11:9]]});
                    end else begin
                        exp_cyc += 6;
                        mr[ins[11:9]] = mm[ea];
                    end
                    pc = pc + 16'd1;
                end
                3'd3: begin
                    exp_cyc += 3;
                    mr[rd] = {6'b0, ins[9:0]};
                    pc = pc + 16'd1;
                end
                3'd4: begin
                    exp_cyc += 3;
                    pc = pc + 16'd1 + 16'(sx(int'(ins[12:0]), 13));
                end
                3'd5: begin
                    exp_cyc += 3;
                    case (ins[12:10])
                        3'd0: taken = mz;
                        3'd1: taken = !mz;
                        3'd2: taken = mc;
                        3'd3: taken = !mc;
                        3'd4: taken = mn;
                        3'd5: taken = !mn;
                        3'd6: taken = 1;
                        default: taken = 0;
                    endcase
                    if (taken) pc = pc + 16'd1 + 16'(sx(int'(ins[9:0]), 10));
                    else pc = pc + 16'd1;
                end
                3'd6: begin
                    exp_cyc += 3;
                    t = mr[ra];
                    mr[rd] = pc + 16'd1;
                    pc = t;
                end
                default: begin
                    exp_cyc += 3;
                    exp_hpc = pc;
                    ok = 1;
                    done = 1;
                end
            endcase
        end
    endtask

    task automatic new_test();
        reset = 1'b0;
        mon_en = 1'b0;
        gen++;
        exp_q.delete();
        @(negedge clk);
    endtask

    // Stores R0..R6 to 0x300+i via R7, then HALT padding.
    task automatic put_epilogue(input int at);
        img[at] = {3'b011, 3'd7, 10'h300};
        for (int i = 0; i < 7; i++) img[at + 1 + i] = {3'b010, 1'b1, 3'(i), 3'd7, 6'(i)};
        for (int i = 0; i < 4; i++) img[at + 8 + i] = 16'hE000;
    endtask

    task automatic run_dut(input string nm);
        int cyc;
        bit done;
        mon_en = 1'b1;
        reset = 1'b1;
        cyc = 0; done = 0;
        while (!done && cyc < exp_cyc + 40) begin
            @(negedge clk);
            cyc++;
            if (hold) done = 1;
        end
        check({nm, "_cycles"}, cyc, exp_cyc);
        check({nm, "_hold"}, {31'h0, hold}, 32'h1);
        check({nm, "_busy"}, {31'h0, busy}, 32'h1);
        check({nm, "_halt_addr"}, {16'h0, bus.address}, {16'h0, exp_hpc});
        repeat (4) @(negedge clk);
        check({nm, "_frozen_addr"}, {16'h0, bus.address}, {16'h0, exp_hpc});
        check({nm, "_halt_write"}, {31'h0, bus.write}, 32'h0);
        check({nm, "_stores_left"}, exp_q.size(), 0);
        mon_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic directed(input string nm);
        bit ok;
        mm = img;
        model_run(ok);
        if (!ok) begin
            n_checks++;
            $display("FAIL %s_model: got no halt expected halt", nm);
        end else begin
            run_dut(nm);
        end
    endtask

    task automatic gen_random();
        int n;
        logic [15:0] w;
        n = $urandom_range(10, 20);
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 9))
                3: w = {3'b001, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 7'($urandom)};
                4: w = {3'b011, 3'($urandom_range(0, 7)), 10'($urandom)};
                5: w = {3'b010, 1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 6'($urandom)};
                6: w = {3'b010, 1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 6'($urandom)};
                7: w = {3'b100, 13'($urandom_range(0, 3))};
                8: w = {3'b101, 3'($urandom_range(0, 7)), 10'($urandom_range(0, 3))};
                default: w = {3'b000, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                              3'($urandom_range(0, 7)),
                              ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7))};
            endcase
            img[k] = w;
        end
        put_epilogue(n);
    endtask

    initial begin
        bit seen, ok;
        int cnt;
        logic [15:0] exp_addr [12];
        logic        exp_busy [12];
        n_checks = 0; n_pass = 0; gen = 1; mon_en = 0;
        reset = 1'b0;
        for (int i = 0; i < 65536; i++) img[i] = 16'($urandom);
        repeat (2) @(negedge clk);

        check("rst_hold", {31'h0, hold}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_write", {31'h0, bus.write}, 32'h0);
        check("rst_data_out", {16'h0, bus.data_out}, 32'h0);
        check("rst_address", {16'h0, bus.address}, 32'h0);

        // LDI / ADD / JMP -1 loop: address and busy trace per cycle
        new_test();
        img[0] = 16'h6257; img[1] = 16'h0480; img[2] = 16'h9FFF;
        exp_addr = '{16'h0, 16'h0, 16'h0, 16'h1, 16'h1, 16'h1, 16'h2, 16'h2, 16'h2, 16'h2, 16'h2, 16'h2};
        exp_busy = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        mon_en = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("seq_addr_%0d", i), {16'h0, bus.address}, {16'h0, exp_addr[i]});
            check($sformatf("seq_busy_%0d", i), {31'h0, busy}, {31'h0, exp_busy[i]});
            check($sformatf("seq_hold_%0d", i), {31'h0, hold}, 32'h0);
            @(negedge clk);
        end

        // one store inside a looping program
        new_test();
        img[2] = 16'h5200; img[3] = 16'h9FFF;
        exp_q.push_back({16'h0257, 16'h0257});
        mon_en = 1'b1;
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("loop_store_count", exp_q.size(), 0);

        // reset asserted during the store cycle
        new_test();
        exp_q.push_back({16'h0257, 16'h0257});
        mon_en = 1'b1;
        reset = 1'b1;
        seen = 0; cnt = 0;
        while (!seen && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (bus.write) seen = 1;
        end
        check("abort_store_seen", {31'h0, seen}, 32'h1);
        #1 reset = 1'b0;
        #1;
        check("abort_write", {31'h0, bus.write}, 32'h0);
        check("abort_data_out", {16'h0, bus.data_out}, 32'h0);
        check("abort_address", {16'h0, bus.address}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        check("abort_no_mem_write", {31'h0, wgen[16'h0257] == gen}, 32'h0);
        exp_q.push_back({16'h0257, 16'h0257});
        reset = 1'b1;
        #1;
        check("restart_address", {16'h0, bus.address}, 32'h0);
        repeat (25) @(negedge clk);
        check("restart_store_count", exp_q.size(), 0);
        check("restart_loop_addr", {16'h0, bus.address}, 32'h3);

        // load round trip
        new_test();
        img[0] = 16'h6005; img[1] = 16'h4040; img[2] = 16'h6405; img[3] = 16'h5040; img[4] = 16'hE000;
        directed("load_rt");

        // flags and branches
        new_test();
        img[0] = 16'h6801; img[1] = 16'h0D21; img[2] = 16'hA001; img[3] = 16'h73FF;
        img[4] = 16'hA801; img[5] = 16'h7407; img[6] = 16'hA401; img[7] = 16'h1821;
        img[8] = 16'hA801; img[9] = 16'h73FF; img[10] = 16'hB001; img[11] = 16'h73FF;
        put_epilogue(12);
        directed("flags_br");

        // JAL, including rd == ra, then HALT
        new_test();
        img[0] = 16'h6810; img[1] = 16'hDD00; img[16'h10] = 16'h5E08;
        img[16'h11] = 16'h6C20; img[16'h12] = 16'hCD80;
        img[16'h20] = 16'h5609; img[16'h21] = 16'hE000;
        directed("jal");

        // HALT reached through JAL at 0x0010
        new_test();
        img[0] = 16'h6810; img[1] = 16'hDD00; img[16'h10] = 16'hE000;
        directed("jal_halt");

        // randomized programs
        for (int t = 0; t < 30; t++) begin
            new_test();
            ok = 0;
            for (int tries = 0; tries < 10 && !ok; tries++) begin
                gen_random();
                mm = img;
                exp_q.delete();
                model_run(ok);
            end
            if (ok) run_dut($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/k16_cpu.md
Name: k16_cpu

Overview:
- Minimal 16-bit multi-cycle CPU core for the K16 system.
- Owns a single 16-bit word-addressed memory bus. Memory is synchronous with one-cycle read latency: data_in reflects mem[address] one clock after address is presented. Writes are committed on the clock edge while write=1.
- Eight general registers R0..R7, a PC, and Z/N/C flags. Executes a fixed 8-opcode ISA.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- hold  out  1  core halted by HALT; cleared only by reset.
- busy  out  1  high in every state except FETCH (instruction in progress).
- address  out  16  memory word address.
- data_in  in  16  read data (mem[address] registered one cycle earlier).
- data_out  out  16  store data; 0 when write=0.
- write  out  1  store strobe, one cycle per store.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC; R0..R7=0; Z=N=C=0; state=FETCH.
  - write=0, hold=0, busy=0, data_out=0, address=PC.
- States and transitions:
  - FETCH: address=PC. Next state WAIT.
  - WAIT: address=PC. Next state EXEC.
  - EXEC: instruction=data_in, latched into IR. Non-memory ops commit regs/flags/PC at the end of EXEC, then go to FETCH.
  - Load: EXEC -> MEM -> MWAIT -> LOAD.
  - Store: EXEC -> MEM (write=1) -> FETCH.
  - HALT state: terminal.
- Cycle counts: non-memory instruction 3 clocks; store 4; load 6.
- PC increments by 1 except on taken jump/branch/JAL. All PC arithmetic is 16-bit wrap-around (0xFFFF+1=0).
- Encoding, op=[15:13]:
  - 000 ALU: rd=[12:10], ra=[9:7], rb=[6:4], func=[3:0].
    - 0 ADD; 1 SUB (ra-rb); 2 AND; 3 OR; 4 XOR; 5 SHL ra by 1; 6 SHR ra by 1, logical; 7 MOV rd=rb.
    - func 8..15: no-op; regs and flags unchanged.
  - 001 ADDI: rd=[12:10], ra=[9:7], rd = ra + sext(imm7 [6:0]).
  - 010 LD/ST: [12]=0 load, 1 store; reg=[11:9], base=[8:6], EA = base + sext(off6 [5:0]).
    - Load: reg = mem[EA].
    - Store: mem[EA] = reg. In MEM: address=EA, data_out=reg, write=1.
  - 011 LDI: rd=[12:10], rd = zext(imm10 [9:0]).
  - 100 JMP: PC = PC + 1 + sext(off13 [12:0]).
  - 101 BR: cond=[12:10], off=[9:0].
    - cond: 0 Z, 1 !Z, 2 C, 3 !C, 4 N, 5 !N, 6 always, 7 never.
    - Taken: PC = PC + 1 + sext(off10). Not taken: PC + 1.
  - 110 JAL: rd=[12:10], ra=[9:7]. PC = old ra; rd = PC + 1. If rd==ra, the target uses the old ra value.
  - 111 HALT: hold=1, busy=1, address stays at HALT's PC, write=0. No further fetches until reset.
- Flags:
  - Only ALU (funcs 0..7) and ADDI update flags. MOV updates Z and N and clears C.
  - Z = result==0; N = result[15].
  - C: ADD/ADDI carry-out of bit 15; SUB borrow (ra<rb unsigned); SHL old bit15; SHR old bit0; AND/OR/XOR clear C.
- Register rules:
  - R0..R7 are all general-purpose (R0 is not hard-wired).
  - Register reads in EXEC see values committed before that cycle.
- Bus rules:
  - write is never high outside the MEM state of a store.
  - data_out = 0 whenever write=0.
- Reset mid-instruction: aborts immediately, no partial write. A store's write drops asynchronously.

Test Plan:
- Reset then run mem[0]=6257, mem[1]=0480, mem[2]=9FFF:
  - address 0,0,0,1,1,1,2,2,2,2,... (JMP -1 loops at 2).
  - write never 1; busy low only in FETCH cycles; hold stays 0.
- Append a store: mem[2]=5200 (ST R1,[R0+0]), mem[3]=9FFF -> exactly one cycle with write=1, address=0257, data_out=0257.
- Load round trip: mem[0]=6005 (LDI R0,5), mem[1]=4040 (LD R0,[R1+0], R1=0), then store R0 to address 5 -> mem[5] holds the value originally at mem[0], i.e. 6005. Load takes 6 clocks.
- Flags and branch:
  - LDI R2,1; SUB R3,R2,R2 -> Z=1, C=0.
  - BR Z,+1 skips the next word.
  - BR NZ falls through.
  - SUB 0-1 sets C=1, N=1, result FFFF.
- JAL/HALT: JAL R7,R2 with R2=0010 -> PC=0010, R7=old PC+1. HALT at 0010 -> hold=1, address frozen at 0010, no write.
- Assert reset low mid-store (in the MEM cycle) -> write drops to 0 at once; after release, fetch restarts at address 0.
